// File: rtl/sr_ff_pkg.sv
// Shared policy encoding and next-state rule for the SR flip-flop bank.
package sr_ff_pkg;

   typedef logic [1:0] sr_policy_t;

   localparam sr_policy_t SR_POL_HOLD   = 2'd0;
   localparam sr_policy_t SR_POL_SET    = 2'd1;
   localparam sr_policy_t SR_POL_RESET  = 2'd2;
   localparam sr_policy_t SR_POL_TOGGLE = 2'd3;

   // s=r=1 is resolved by the policy; every other combination is plain SR.
   function automatic logic sr_next_state(input logic q,
                                          input logic s,
                                          input logic r,
                                          input sr_policy_t policy);
      logic nxt;
      nxt = q;
      unique case ({s, r})
         2'b00: nxt = q;
         2'b01: nxt = 1'b0;
         2'b10: nxt = 1'b1;
         2'b11: begin
            unique case (policy)
               SR_POL_HOLD:   nxt = q;
               SR_POL_SET:    nxt = 1'b1;
               SR_POL_RESET:  nxt = 1'b0;
               SR_POL_TOGGLE: nxt = ~q;
               default:       nxt = q;
            endcase
         end
         default: nxt = q;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// Single SR register bit; q1 comes from the same flop so it can never agree with q.
// SR_FF_ILLEGAL_FLAG_EN adds the per-bit s=r=1 detect used by the top-level flag.
module sr_ff_bit
   import sr_ff_pkg::*;
#(
   parameter sr_policy_t POLICY      = SR_POL_HOLD,
   parameter logic       RESET_VALUE = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic s,
   input  logic r,
   output logic q,
   output logic q1
`ifdef SR_FF_ILLEGAL_FLAG_EN
   ,
   output logic illegal_hit
`endif
);

   logic q_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q_reg <= RESET_VALUE;
      end else begin
         q_reg <= sr_next_state(q_reg, s, r, POLICY);
      end
   end

   assign q  = q_reg;
   assign q1 = ~q_reg;

`ifdef SR_FF_ILLEGAL_FLAG_EN
   assign illegal_hit = s & r;
`endif

endmodule

// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR flip-flops with a selectable s=r=1 policy.
// Define SR_FF_ILLEGAL_FLAG_EN to add the sticky 'illegal' output.
module sr_flip_flop
   import sr_ff_pkg::*;
#(
   parameter int unsigned          WIDTH          = 1,
   parameter int unsigned          INVALID_POLICY = 0,
   parameter logic [WIDTH-1:0]     RESET_VALUE    = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] s,
   input  logic [WIDTH-1:0] r,
   output logic [WIDTH-1:0] q,
   output logic [WIDTH-1:0] q1
`ifdef SR_FF_ILLEGAL_FLAG_EN
   ,
   output logic             illegal
`endif
);

   if (INVALID_POLICY > 3) begin : g_bad_policy
      $error("sr_flip_flop: INVALID_POLICY must be in 0..3");
   end

   localparam sr_policy_t POLICY = sr_policy_t'(INVALID_POLICY);

`ifdef SR_FF_ILLEGAL_FLAG_EN
   logic [WIDTH-1:0] hit;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      sr_ff_bit #(
         .POLICY      (POLICY),
         .RESET_VALUE (RESET_VALUE[i])
      ) u_bit (
         .clk         (clk),
         .rst_n       (rst_n),
         .s           (s[i]),
         .r           (r[i]),
         .q           (q[i]),
         .q1          (q1[i])
`ifdef SR_FF_ILLEGAL_FLAG_EN
         ,
         .illegal_hit (hit[i])
`endif
      );
   end

`ifdef SR_FF_ILLEGAL_FLAG_EN
   // Sticky: once any bit sees s=r=1 outside reset, only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         illegal <= 1'b0;
      end else if (|hit) begin
         illegal <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_sr_flip_flop.sv
// Checks five 4-bit SR banks (all four policies plus a non-zero reset value)
// against a vector-level model, with directed sequences then random stimulus.
module tb_sr_flip_flop;

   localparam int N = 5;
   localparam int W = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n = 1'b0;
   logic [W-1:0] s = '0;
   logic [W-1:0] r = '0;

   logic [W-1:0] qArr  [N];
   logic [W-1:0] q1Arr [N];
`ifdef SR_FF_ILLEGAL_FLAG_EN
   logic         illArr [N];
`endif

   for (genvar g = 0; g < N; g++) begin : g_dut
      sr_flip_flop #(
         .WIDTH          (W),
         .INVALID_POLICY ((g == 4) ? 3 : g),
         .RESET_VALUE    ((g == 4) ? 4'b1011 : 4'b0000)
      ) dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .s       (s),
         .r       (r),
         .q       (qArr[g]),
         .q1      (q1Arr[g])
`ifdef SR_FF_ILLEGAL_FLAG_EN
         ,
         .illegal (illArr[g])
`endif
      );
   end

   int errorCount = 0;
   int checkCount = 0;

   logic [W-1:0] modelQ   [N];
   logic         modelIll [N];

   function automatic int policyOf(input int idx);
      return (idx == 4) ? 3 : idx;
   endfunction

   function automatic logic [W-1:0] resetOf(input int idx);
      return (idx == 4) ? 4'b1011 : 4'b0000;
   endfunction

   // Whole-vector view: resolve the unambiguous bits first, then apply the policy to s=r=1 bits.
   function automatic logic [W-1:0] refNext(input int policy, input logic [W-1:0] cur,
                                            input logic [W-1:0] sIn, input logic [W-1:0] rIn);
      logic [W-1:0] both;
      logic [W-1:0] base;
      both = sIn & rIn;
      base = (cur | (sIn & ~rIn)) & ~(rIn & ~sIn);
      case (policy)
         1:       return base | both;
         2:       return base & ~both;
         3:       return base ^ both;
         default: return base;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                              input logic [W-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input string tag, input logic rstIn,
                                input logic [W-1:0] sIn, input logic [W-1:0] rIn);
      @(negedge clk);
      rst_n = rstIn;
      s     = sIn;
      r     = rIn;
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
         if (!rstIn) begin
            modelQ[i]   = resetOf(i);
            modelIll[i] = 1'b0;
         end else begin
            modelQ[i]   = refNext(policyOf(i), modelQ[i], sIn, rIn);
            modelIll[i] = modelIll[i] | ((sIn & rIn) != '0);
         end
      end
      #1;
      for (int i = 0; i < N; i++) begin
         checkOutput($sformatf("%s_q%0d", tag, i), qArr[i], modelQ[i]);
         checkOutput($sformatf("%s_q1_%0d", tag, i), q1Arr[i], ~modelQ[i]);
`ifdef SR_FF_ILLEGAL_FLAG_EN
         checkOutput($sformatf("%s_ill%0d", tag, i), {3'b000, illArr[i]}, {3'b000, modelIll[i]});
`endif
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         modelQ[i]   = 'x;
         modelIll[i] = 1'b0;
      end

      applyStimulus("reset", 1'b0, 4'h0, 4'h0);
      applyStimulus("reset_with_s", 1'b0, 4'hF, 4'h0);

      applyStimulus("pat00", 1'b1, 4'h0, 4'h0);
      applyStimulus("pat01", 1'b1, 4'h0, 4'hF);
      applyStimulus("pat10", 1'b1, 4'hF, 4'h0);
      applyStimulus("pat11", 1'b1, 4'hF, 4'hF);

      applyStimulus("preset", 1'b1, 4'hF, 4'h0);
      applyStimulus("both_a", 1'b1, 4'hF, 4'hF);
      applyStimulus("both_b", 1'b1, 4'hF, 4'hF);

      applyStimulus("clear", 1'b1, 4'h0, 4'hF);
      applyStimulus("multibit", 1'b1, 4'b1010, 4'b0101);
      applyStimulus("mb_hold", 1'b1, 4'h0, 4'h0);

      applyStimulus("set_all", 1'b1, 4'hF, 4'h0);
      applyStimulus("mid_reset", 1'b0, 4'hF, 4'h0);
      applyStimulus("post_reset", 1'b1, 4'h0, 4'h0);

      applyStimulus("ill_edge", 1'b1, 4'b0100, 4'b0100);
      applyStimulus("ill_hold1", 1'b1, 4'h0, 4'h0);
      applyStimulus("ill_hold2", 1'b1, 4'h0, 4'h0);
      applyStimulus("ill_reset", 1'b0, 4'h0, 4'h0);

      for (int k = 0; k < 300; k++) begin
         applyStimulus($sformatf("rand%0d", k), ($urandom_range(19) != 0),
                       W'($urandom), W'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
